// File: rtl/rng_axi_writer_if.sv
// Bus bundle for rng_axi_writer: RNG input stream, AXI4 write master and soft-register port.
interface rng_axi_writer_if;
    logic [511:0] rnd_data;
    logic         rnd_valid;
    logic         rnd_ready;

    logic [15:0]  awid_m;
    logic [63:0]  awaddr_m;
    logic [7:0]   awlen_m;
    logic [2:0]   awsize_m;
    logic         awvalid_m;
    logic         awready_m;

    logic [511:0] wdata_m;
    logic [63:0]  wstrb_m;
    logic         wlast_m;
    logic         wvalid_m;
    logic         wready_m;

    logic [15:0]  bid_m;
    logic [1:0]   bresp_m;
    logic         bvalid_m;
    logic         bready_m;

    logic         softreg_req_valid;
    logic         softreg_req_isWrite;
    logic [31:0]  softreg_req_addr;
    logic [63:0]  softreg_req_data;
    logic         softreg_resp_valid;
    logic [63:0]  softreg_resp_data;

    modport master (
        input  rnd_data, rnd_valid,
        output rnd_ready,
        output awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
        input  awready_m,
        output wdata_m, wstrb_m, wlast_m, wvalid_m,
        input  wready_m,
        input  bid_m, bresp_m, bvalid_m,
        output bready_m,
        input  softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
        output softreg_resp_valid, softreg_resp_data
    );

    modport slave (
        output rnd_data, rnd_valid,
        input  rnd_ready,
        input  awid_m, awaddr_m, awlen_m, awsize_m, awvalid_m,
        output awready_m,
        input  wdata_m, wstrb_m, wlast_m, wvalid_m,
        output wready_m,
        output bid_m, bresp_m, bvalid_m,
        input  bready_m,
        output softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
        input  softreg_resp_valid, softreg_resp_data
    );
endinterface

// File: rtl/rng_axi_writer.sv
// Drains a 512-bit random word stream into AXI4 INCR write bursts, configured via soft registers.
//  state   | meaning
//  IDLE    | waiting for START
//  ADDR    | presenting AW for next burst (gated by outstanding limit)
//  DATA    | streaming W beats of current burst
//  DRAIN   | all beats sent, waiting for remaining B responses
//  DONE    | job finished, one cycle before IDLE
module rng_axi_writer #(
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned MAX_OUTSTAND = 4,
    parameter logic [15:0] AXI_ID       = 16'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    rng_axi_writer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_DONE} state_e;

    state_e       state_q, state_d;
    logic [63:0]  base_q, nbeats_q, addr_q, remain_q;
    logic [47:0]  written_q;
    logic [7:0]   beat_cnt_q;
    logic [3:0]   outst_q;
    logic         err_q;
    logic         resp_valid_q;
    logic [63:0]  resp_data_q, rd_data;

    logic         sr_wr, sr_rd, busy, start_go;
    logic         awvalid, wvalid, rnd_ready, wlast;
    logic         aw_fire, w_fire, b_fire;
    logic [7:0]   burst_beats;
    logic         unused_bid;

    assign sr_wr    = bus.softreg_req_valid && bus.softreg_req_isWrite;
    assign sr_rd    = bus.softreg_req_valid && !bus.softreg_req_isWrite;
    assign busy     = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_DRAIN);
    assign start_go = sr_wr && (bus.softreg_req_addr == 32'h10) && !busy;

    assign burst_beats = (remain_q >= 64'(BURST_LEN)) ? 8'(BURST_LEN) : remain_q[7:0];
    assign aw_fire     = awvalid && bus.awready_m;
    assign w_fire      = wvalid && bus.wready_m;
    assign b_fire      = bus.bvalid_m;
    assign unused_bid  = ^bus.bid_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_go) state_d = (nbeats_q == 64'd0) ? S_DONE : S_ADDR;
                else          state_d = S_IDLE;
            end
            S_ADDR:  if (aw_fire) state_d = S_DATA;
            S_DATA:  if (w_fire && beat_cnt_q == 8'd1)
                         state_d = (remain_q == 64'd1) ? S_DRAIN : S_ADDR;
            S_DRAIN: if (outst_q == 4'd0) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // awvalid depends only on registered state, never on the input stream
    always_comb begin
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        rnd_ready = 1'b0;
        wlast     = 1'b0;
        case (state_q)
            S_ADDR: awvalid = (outst_q < 4'(MAX_OUTSTAND));
            S_DATA: begin
                wvalid    = bus.rnd_valid;
                rnd_ready = bus.wready_m;
                wlast     = (beat_cnt_q == 8'd1);
            end
            default: ;
        endcase
    end

    assign bus.awvalid_m = awvalid;
    assign bus.awid_m    = AXI_ID;
    assign bus.awaddr_m  = addr_q;
    assign bus.awlen_m   = burst_beats - 8'd1;
    assign bus.awsize_m  = 3'b110;
    assign bus.wvalid_m  = wvalid;
    assign bus.wdata_m   = bus.rnd_data;
    assign bus.wstrb_m   = '1;
    assign bus.wlast_m   = wlast;
    assign bus.rnd_ready = rnd_ready;
    assign bus.bready_m  = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            remain_q   <= '0;
            written_q  <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (start_go) begin
            addr_q    <= base_q;
            remain_q  <= nbeats_q;
            written_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (aw_fire) beat_cnt_q <= burst_beats;
            if (w_fire) begin
                beat_cnt_q <= beat_cnt_q - 8'd1;
                remain_q   <= remain_q - 64'd1;
                written_q  <= written_q + 48'd1;
                addr_q     <= addr_q + 64'd64;
            end
            if (b_fire && bus.bresp_m != 2'b00) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) outst_q <= '0;
        else if (aw_fire && !b_fire) outst_q <= outst_q + 4'd1;
        else if (b_fire && !aw_fire) outst_q <= outst_q - 4'd1;
    end

    // BASE/NBEATS are only sampled on START, so writes while busy are harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            nbeats_q <= '0;
        end else if (sr_wr) begin
            if (bus.softreg_req_addr == 32'h00) base_q   <= {bus.softreg_req_data[63:12], 12'h000};
            if (bus.softreg_req_addr == 32'h08) nbeats_q <= bus.softreg_req_data;
        end
    end

    always_comb begin
        rd_data = '0;
        case (bus.softreg_req_addr)
            32'h00:  rd_data = base_q;
            32'h08:  rd_data = nbeats_q;
            32'h18:  rd_data = {busy, err_q, 14'h0, written_q};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= sr_rd;
            if (sr_rd) resp_data_q <= rd_data;
        end
    end

    assign bus.softreg_resp_valid = resp_valid_q;
    assign bus.softreg_resp_data  = resp_data_q;
endmodule
